// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system-ID words and checks them against build-time values.
// Define SYSID_CHECK_TS_EN to also read and compare the timestamp word (address 1).
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5DE8_CFBD,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        avm_address_o,
  output logic        avm_read_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        id_ok_o,
  output logic        ts_ok_o,
  output logic        timeout_err_o,
  output logic [31:0] captured_id_o,
  output logic [31:0] captured_ts_o
);

`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_RD_TS, S_GAP, S_CHECK} state_t;

  state_t      state_q, state_d, ret_q, ret_d;
  logic [15:0] wait_q, wait_d;
  logic [3:0]  retry_q, retry_d;
  logic        got_id_q, got_id_d, got_ts_q, got_ts_d;
  logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic        pass_q, pass_d, terr_q, terr_d, done_q, done_d;
  logic        rd_d, addr_d;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    wait_d   = wait_q;
    retry_d  = retry_q;
    got_id_d = got_id_q;
    got_ts_d = got_ts_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    pass_d   = pass_q;
    terr_d   = terr_q;
    done_d   = 1'b0;
    rd_d     = 1'b0;
    addr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RD_ID;
          wait_d   = '0;
          retry_d  = '0;
          got_id_d = 1'b0;
          got_ts_d = 1'b0;
          cap_id_d = '0;
          cap_ts_d = '0;
          id_ok_d  = 1'b0;
          ts_ok_d  = 1'b0;
          pass_d   = 1'b0;
          terr_d   = 1'b0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        rd_d   = 1'b1;
        addr_d = (state_q == S_RD_TS);
        if (!avm_waitrequest_i) begin
          wait_d  = '0;
          retry_d = '0;
          state_d = S_GAP;
          if (state_q == S_RD_ID) begin
            cap_id_d = avm_readdata_i;
            got_id_d = 1'b1;
            ret_d    = TS_EN ? S_RD_TS : S_CHECK;
          end else begin
            cap_ts_d = TS_EN ? avm_readdata_i : 32'h0;
            got_ts_d = TS_EN;
            ret_d    = S_CHECK;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Attempt expired: either give up on the whole sequence or drop read for one cycle and retry.
          wait_d = '0;
          if (retry_q == RETRY_MAX) begin
            terr_d  = 1'b1;
            state_d = S_CHECK;
          end else begin
            retry_d = retry_q + 4'd1;
            ret_d   = state_q;
            state_d = S_GAP;
          end
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_GAP: state_d = ret_q;
      S_CHECK: begin
        id_ok_d = got_id_q && (cap_id_q == EXPECTED_ID);
        ts_ok_d = TS_EN ? (got_ts_q && (cap_ts_q == EXPECTED_TS)) : 1'b1;
        pass_d  = id_ok_d && ts_ok_d && !terr_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      wait_q   <= '0;
      retry_q  <= '0;
      got_id_q <= 1'b0;
      got_ts_q <= 1'b0;
      cap_id_q <= '0;
      cap_ts_q <= '0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      pass_q   <= 1'b0;
      terr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      wait_q   <= wait_d;
      retry_q  <= retry_d;
      got_id_q <= got_id_d;
      got_ts_q <= got_ts_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      pass_q   <= pass_d;
      terr_q   <= terr_d;
      done_q   <= done_d;
    end
  end

  assign avm_read_o    = rd_d;
  assign avm_address_o = addr_d;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign id_ok_o       = id_ok_q;
  assign ts_ok_o       = ts_ok_q;
  assign timeout_err_o = terr_q;
  assign captured_id_o = cap_id_q;
  assign captured_ts_o = cap_ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master: two instances (default timing, short timeout) driven by
// reactive latency slaves and checked against a transaction-level cost/result model.
module tb_sysid_check_master;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5DE8_CFBD;
  localparam int TO[2] = '{255, 8};
  localparam int RT[2] = '{3, 1};

  typedef struct packed {
    int lat; int att; int rd0; int a1; int dones; int glitch;
    logic busy; logic pass; logic id_ok; logic ts_ok; logic terr;
    logic [31:0] cap_id; logic [31:0] cap_ts;
  } res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] start = 2'b00;
  logic [1:0] rd, addr, wr, busy, done, pass, idok, tsok, terr;
  logic [31:0] rdata [2];
  logic [31:0] capid [2];
  logic [31:0] capts [2];

  int lat_id [2] = '{0, 0};
  int lat_ts [2] = '{0, 0};
  logic [31:0] dat_id [2] = '{32'h0, 32'h0};
  logic [31:0] dat_ts [2] = '{32'h0, 32'h0};
  int rcnt [2] = '{0, 0};
  int cyc = 0;
  int n_att [2] = '{0, 0};
  int n_rd0 [2] = '{0, 0};
  int n_a1 [2] = '{0, 0};
  int n_done [2] = '{0, 0};
  int n_gl [2] = '{0, 0};
  logic [1:0] rd_p = 2'b00, addr_p = 2'b00;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sysid_check_master dut (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]),
    .avm_address_o(addr[0]), .avm_read_o(rd[0]), .avm_waitrequest_i(wr[0]), .avm_readdata_i(rdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .id_ok_o(idok[0]), .ts_ok_o(tsok[0]),
    .timeout_err_o(terr[0]), .captured_id_o(capid[0]), .captured_ts_o(capts[0]));

  sysid_check_master #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(1)) dut_to (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]),
    .avm_address_o(addr[1]), .avm_read_o(rd[1]), .avm_waitrequest_i(wr[1]), .avm_readdata_i(rdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .id_ok_o(idok[1]), .ts_ok_o(tsok[1]),
    .timeout_err_o(terr[1]), .captured_id_o(capid[1]), .captured_ts_o(capts[1]));

  // Slaves stall each attempt for the configured number of cycles, then accept.
  assign wr[0] = rd[0] && (rcnt[0] < (addr[0] ? lat_ts[0] : lat_id[0]));
  assign wr[1] = rd[1] && (rcnt[1] < (addr[1] ? lat_ts[1] : lat_id[1]));
  assign rdata[0] = addr[0] ? dat_ts[0] : dat_id[0];
  assign rdata[1] = addr[1] ? dat_ts[1] : dat_id[1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      rcnt[i] <= (rd[i] && wr[i]) ? rcnt[i] + 1 : 0;
      if (rd[i] && !rd_p[i]) n_att[i] <= n_att[i] + 1;
      if (rd[i] && !addr[i]) n_rd0[i] <= n_rd0[i] + 1;
      if (rd[i] && addr[i]) n_a1[i] <= n_a1[i] + 1;
      if (done[i]) n_done[i] <= n_done[i] + 1;
      if (rd[i] && rd_p[i] && addr[i] != addr_p[i]) n_gl[i] <= n_gl[i] + 1;
    end
    rd_p <= rd;
    addr_p <= addr;
  end

  // Transaction-level model: each accepted word costs its stall cycles + 1 read + 1 gap; a dead word
  // costs (R+1) attempts of T cycles with R one-cycle gaps and ends the sequence.
  task automatic predict(input int i, input int lid, input int lts, input logic [31:0] did,
                         input logic [31:0] dts, output res_t e);
    int t, r;
    bit idf, tsf;
    t = TO[i]; r = RT[i];
    e = '0;
    e.lat = 1;
    idf = (lid < t);
    tsf = 1'b1;
    if (idf) begin e.lat += lid + 2; e.att = 1; e.rd0 = lid + 1; end
    else begin e.lat += (r + 1) * t + r; e.att = r + 1; e.rd0 = (r + 1) * t; end
    if (TS_EN && idf) begin
      tsf = (lts < t);
      if (tsf) begin e.lat += lts + 2; e.att += 1; e.a1 = lts + 1; end
      else begin e.lat += (r + 1) * t + r; e.att += r + 1; e.a1 = (r + 1) * t; end
    end
    e.lat += 1;
    e.dones = 1;
    e.id_ok = idf && (did == EXP_ID);
    e.ts_ok = TS_EN ? (idf && tsf && dts == EXP_TS) : 1'b1;
    e.terr = !idf || !tsf;
    e.pass = e.id_ok && e.ts_ok && !e.terr;
    e.cap_id = idf ? did : 32'h0;
    e.cap_ts = (TS_EN && idf && tsf) ? dts : 32'h0;
  endtask

  task automatic run_seq(input int i, input int lid, input int lts, input logic [31:0] did,
                         input logic [31:0] dts, input int restart_at, output res_t o);
    int n, a0, r0, b0, d0, g0;
    @(negedge clk);
    lat_id[i] = lid; lat_ts[i] = lts; dat_id[i] = did; dat_ts[i] = dts;
    start[i] = 1'b1;
    n = cyc; a0 = n_att[i]; r0 = n_rd0[i]; b0 = n_a1[i]; d0 = n_done[i]; g0 = n_gl[i];
    do begin
      @(negedge clk);
      start[i] = (restart_at > 0) && (cyc - n == restart_at);
    end while (!done[i] && cyc - n < 3000);
    o = '0;
    o.lat = cyc - n;
    o.busy = busy[i]; o.pass = pass[i]; o.id_ok = idok[i]; o.ts_ok = tsok[i]; o.terr = terr[i];
    o.cap_id = capid[i]; o.cap_ts = capts[i];
    @(negedge clk);
    start[i] = 1'b0;
    o.att = n_att[i] - a0; o.rd0 = n_rd0[i] - r0; o.a1 = n_a1[i] - b0;
    o.dones = n_done[i] - d0; o.glitch = n_gl[i] - g0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rd, addr, busy, done, pass, idok, tsok, terr} !== '0 || capid[0] !== 0 || capts[0] !== 0 || capid[1] !== 0)
      begin miscompares++; $display("FAIL reset_state got %b exp 0", {rd, addr, busy, done, pass, idok, tsok, terr}); end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b0 || rd[0] !== 1'b0)
      begin miscompares++; $display("FAIL reset_wins_start got busy=%b rd=%b exp 0 0", busy[0], rd[0]); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait;
    res_t o, e;
    run_seq(0, 0, 0, EXP_ID, EXP_TS, 0, o);
    predict(0, 0, 0, EXP_ID, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL zero_wait got %p exp %p", o, e); end
    vectors++;
    if (o.lat !== (TS_EN ? 6 : 4) || o.pass !== 1'b1 || o.ts_ok !== 1'b1 || o.a1 !== (TS_EN ? 1 : 0))
      begin miscompares++; $display("FAIL zero_wait_latency got %0d pass=%b a1=%0d", o.lat, o.pass, o.a1); end
  endtask

  task automatic test_bad_id;
    res_t o, e;
    run_seq(0, 0, 0, 32'h0000_0001, EXP_TS, 0, o);
    predict(0, 0, 0, 32'h0000_0001, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL bad_id got %p exp %p", o, e); end
    vectors++;
    if (o.pass !== 1'b0 || o.id_ok !== 1'b0 || o.ts_ok !== 1'b1 || o.cap_id !== 32'h1)
      begin miscompares++; $display("FAIL bad_id_flags got pass=%b id_ok=%b ts_ok=%b cap=%h", o.pass, o.id_ok, o.ts_ok, o.cap_id); end
  endtask

  task automatic test_wait_states;
    res_t o, e;
    run_seq(0, 10, 4, EXP_ID, EXP_TS, 0, o);
    predict(0, 10, 4, EXP_ID, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL wait_states got %p exp %p", o, e); end
    vectors++;
    if (o.rd0 !== 11 || o.att !== (TS_EN ? 2 : 1) || o.glitch !== 0 || o.pass !== 1'b1)
      begin miscompares++; $display("FAIL wait_states_stable got rd0=%0d att=%0d gl=%0d", o.rd0, o.att, o.glitch); end
  endtask

  task automatic test_timeout;
    res_t o, e;
    run_seq(1, 1000, 1000, EXP_ID, EXP_TS, 0, o);
    predict(1, 1000, 1000, EXP_ID, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL timeout_short got %p exp %p", o, e); end
    vectors++;
    if (o.att !== 2 || o.rd0 !== 16 || o.lat !== 19 || o.terr !== 1'b1 || o.pass !== 1'b0 || o.dones !== 1)
      begin miscompares++; $display("FAIL timeout_shape got att=%0d rd0=%0d lat=%0d terr=%b", o.att, o.rd0, o.lat, o.terr); end
    run_seq(0, 300, 0, EXP_ID, EXP_TS, 0, o);
    predict(0, 300, 0, EXP_ID, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL timeout_default got %p exp %p", o, e); end
    run_seq(1, 7, 8, EXP_ID, EXP_TS, 0, o);
    predict(1, 7, 8, EXP_ID, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL timeout_edge got %p exp %p", o, e); end
  endtask

  task automatic test_back_to_back;
    res_t o, e;
    run_seq(0, 2, 1, EXP_ID, 32'h1111_2222, 3, o);
    predict(0, 2, 1, EXP_ID, 32'h1111_2222, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL restart_ignored got %p exp %p", o, e); end
    run_seq(0, 0, 0, EXP_ID, EXP_TS, 0, o);
    predict(0, 0, 0, EXP_ID, EXP_TS, e);
    vectors++;
    if (o !== e) begin miscompares++; $display("FAIL back_to_back got %p exp %p", o, e); end
  endtask

  task automatic test_random;
    res_t o, e;
    int lid, lts;
    logic [31:0] did, dts;
    for (int k = 0; k < 16; k++) begin
      lid = $urandom_range(0, 12);
      lts = $urandom_range(0, 12);
      did = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      dts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      run_seq(k % 2, lid, lts, did, dts, 0, o);
      predict(k % 2, lid, lts, did, dts, e);
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL random_%0d got %p exp %p", k, o, e); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    lat_id[0] = 0; lat_ts[0] = 40; dat_id[0] = 32'h0000_1234; dat_ts[0] = EXP_TS;
    if (!TS_EN) lat_id[0] = 40;
    start[0] = 1'b1;
    n = cyc;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc - n < 8) begin
      @(negedge clk);
      start[0] = (cyc - n == 5);
    end
    start[0] = 1'b0;
    vectors++;
    if ({busy[0], rd[0], addr[0], done[0]} !== {1'b1, 1'b1, TS_EN, 1'b0})
      begin miscompares++; $display("FAIL mid_read_state got %b exp %b", {busy[0], rd[0], addr[0], done[0]}, {1'b1, 1'b1, TS_EN, 1'b0}); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rd[0], addr[0], busy[0], done[0], pass[0], idok[0], tsok[0], terr[0]} !== 8'h00 || capid[0] !== 0 || capts[0] !== 0)
      begin miscompares++; $display("FAIL reset_mid got %b cap=%h exp 0", {rd[0], addr[0], busy[0], done[0], pass[0], idok[0], tsok[0], terr[0]}, capid[0]); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_bad_id();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
